// File: rtl/sym_pkg.sv
// Shared widths and the buffered word entry for the 2-bit symbol packer.
package sym_pkg;
  localparam int SYM_W         = 2;
  localparam int WORD_W        = 32;
  localparam int SYMS_PER_WORD = WORD_W / SYM_W;
  localparam int CNT_W         = $clog2(SYMS_PER_WORD);
  localparam int LEN_W         = CNT_W + 1;

  typedef struct packed {
    logic [WORD_W-1:0] word;
    logic [LEN_W-1:0]  len;
  } entry_t;
endpackage

// File: rtl/sym_pack_2to32_fifo2_reg.sv
// Two-entry register FIFO with a registered head; push into a full FIFO only
// succeeds when a pop frees a slot on the same edge.
module fifo2_reg #(
  parameter int ENTRY_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push_i,
  input  logic [ENTRY_W-1:0] din_i,
  input  logic               pop_i,
  output logic [ENTRY_W-1:0] head_o,
  output logic               valid_o,
  output logic [1:0]         fcnt_o,
  output logic               pushed_o
);
  logic [ENTRY_W-1:0] e0_q, e1_q;
  logic [1:0]         fcnt_q;
  logic               pop_ok, push_ok;

  assign pop_ok  = pop_i && (fcnt_q != 2'd0);
  assign push_ok = push_i && ((fcnt_q != 2'd2) || pop_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_q   <= '0;
      e1_q   <= '0;
      fcnt_q <= 2'd0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (fcnt_q == 2'd0) e0_q <= din_i;
          else                e1_q <= din_i;
          fcnt_q <= fcnt_q + 2'd1;
        end
        2'b01: begin
          e0_q   <= e1_q;
          fcnt_q <= fcnt_q - 2'd1;
        end
        2'b11: begin
          if (fcnt_q == 2'd1) begin
            e0_q <= din_i;
          end else begin
            e0_q <= e1_q;
            e1_q <= din_i;
          end
        end
        default: ;
      endcase
    end
  end

  assign head_o   = e0_q;
  assign valid_o  = (fcnt_q != 2'd0);
  assign fcnt_o   = fcnt_q;
  assign pushed_o = push_ok;
endmodule

// File: rtl/sym_pack_2to32.sv
// Packs an LSB-first stream of symbols into words, with flush of partial
// words and a two-entry output buffer on a valid/ready word port.
module sym_pack_2to32 #(
  parameter int WORD_W = sym_pkg::WORD_W,
  parameter int SYM_W  = sym_pkg::SYM_W
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              en,
  input  logic                              sym_valid,
  input  logic [SYM_W-1:0]                  sym_in,
  output logic                              sym_ready,
  input  logic                              flush,
  output logic                              word_valid,
  input  logic                              word_ready,
  output logic [WORD_W-1:0]                 word_out,
  output logic [$clog2(WORD_W/SYM_W):0]     word_len,
  output logic                              overflow
);
  localparam int SPW     = WORD_W / SYM_W;
  localparam int CW      = $clog2(SPW);
  localparam int LW      = CW + 1;
  localparam int ENTRY_W = WORD_W + LW;

  logic [WORD_W-1:0]  asm_q, asm_d, asm_mrg;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [1:0]         fcnt;
  logic               sym_acc, flush_acc, word_done, push, pushed;
  logic [LW-1:0]      push_len;
  logic [ENTRY_W-1:0] head;

  assign sym_ready = !((fcnt == 2'd2) && (cnt_q != '0));
  assign sym_acc   = en && sym_valid && sym_ready;
  assign flush_acc = en && flush && sym_ready;
  assign word_done = sym_acc && (cnt_q == CW'(SPW - 1));
  assign push      = word_done || (flush_acc && ((cnt_q != '0) || sym_acc));
  assign push_len  = word_done ? LW'(SPW) : ({1'b0, cnt_q} + LW'(sym_acc));

  always_comb begin
    asm_mrg = asm_q;
    if (sym_acc) asm_mrg[int'(cnt_q)*SYM_W +: SYM_W] = sym_in;
  end

  // A flush with a lone symbol into a full, non-popping buffer cannot push;
  // the symbol is kept as the start of the next word instead.
  always_comb begin
    asm_d = asm_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (en && sym_valid && !sym_ready) ovf_d = 1'b1;
    if (pushed) begin
      asm_d = '0;
      cnt_d = '0;
    end else if (sym_acc) begin
      asm_d = asm_mrg;
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      asm_q <= asm_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  fifo2_reg #(.ENTRY_W(ENTRY_W)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_i   (push),
    .din_i    ({asm_mrg, push_len}),
    .pop_i    (word_ready),
    .head_o   (head),
    .valid_o  (word_valid),
    .fcnt_o   (fcnt),
    .pushed_o (pushed)
  );

  assign word_out = head[ENTRY_W-1:LW];
  assign word_len = head[LW-1:0];
  assign overflow = ovf_q;
endmodule

// File: tb/tb_sym_pack_2to32.sv
// Randomised and directed bench for sym_pack_2to32 against a queue-based model.
module tb_sym_pack_2to32;
  import sym_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0, sym_valid = 1'b0, flush = 1'b0, word_ready = 1'b0;
  logic [1:0]  sym_in = 2'd0;
  logic        sym_ready, word_valid, overflow;
  logic [31:0] word_out;
  logic [4:0]  word_len;

  int n_cmp = 0;
  int n_bad = 0;

  entry_t     exp_q[$];
  logic [1:0] cur[$];
  bit         ovf_m;

  sym_pack_2to32 dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sym_valid(sym_valid), .sym_in(sym_in),
    .sym_ready(sym_ready), .flush(flush), .word_valid(word_valid),
    .word_ready(word_ready), .word_out(word_out), .word_len(word_len),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic bit m_ready();
    return !(exp_q.size() == 2 && cur.size() != 0);
  endfunction

  function automatic entry_t m_entry();
    entry_t e;
    e.word = '0;
    foreach (cur[i]) e.word = e.word + (32'(cur[i]) << (2 * i));
    e.len = 5'(cur.size());
    return e;
  endfunction

  task automatic m_clear();
    exp_q.delete();
    cur.delete();
    ovf_m = 1'b0;
  endtask

  // Drive one cycle from a negedge, advance the model, land on the next negedge.
  task automatic cyc(input bit v, input logic [1:0] s, input bit f, input bit e, input bit wr);
    bit rdy, pop, sacc, facc, push;
    entry_t ent;
    sym_valid = v; sym_in = s; flush = f; en = e; word_ready = wr;
    rdy  = m_ready();
    pop  = wr && exp_q.size() != 0;
    sacc = e && v && rdy;
    facc = e && f && rdy;
    if (e && v && !rdy) ovf_m = 1'b1;
    if (sacc) cur.push_back(s);
    push = (sacc && cur.size() == 16) ||
           (facc && cur.size() != 0 && (exp_q.size() < 2 || pop));
    ent = m_entry();
    if (pop) void'(exp_q.pop_front());
    if (push) begin
      exp_q.push_back(ent);
      cur.delete();
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic release_reset();
    sym_valid = 0; flush = 0; en = 0; word_ready = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    m_clear();
    rst_n = 1'b0;
    #1;
    n_cmp++; if (word_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", word_valid); end
    n_cmp++; if (word_out !== 32'h0) begin n_bad++; $display("FAIL rst_word: got %h want 0", word_out); end
    n_cmp++; if (word_len !== 5'd0) begin n_bad++; $display("FAIL rst_len: got %0d want 0", word_len); end
    n_cmp++; if (sym_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b want 1", sym_ready); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL rst_ovf: got %b want 0", overflow); end
    release_reset();
  endtask

  task automatic test_full_word();
    for (int i = 0; i < 16; i++) begin
      cyc(1, 2'(i % 4), 0, 1, 1);
      if (i == 14) begin
        n_cmp++; if (word_valid !== 1'b0) begin n_bad++; $display("FAIL full_early_valid: got %b want 0", word_valid); end
      end
    end
    n_cmp++; if (word_valid !== 1'b1) begin n_bad++; $display("FAIL full_valid: got %b want 1", word_valid); end
    n_cmp++; if (word_out !== 32'hE4E4_E4E4) begin n_bad++; $display("FAIL full_word: got %h want e4e4e4e4", word_out); end
    n_cmp++; if (word_len !== 5'd16) begin n_bad++; $display("FAIL full_len: got %0d want 16", word_len); end
    cyc(0, 0, 0, 1, 1);
    n_cmp++; if (word_valid !== 1'b0) begin n_bad++; $display("FAIL full_pop: got %b want 0", word_valid); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) cyc(1, 2'b11, 0, 1, 1);
    cyc(0, 0, 1, 1, 1);
    n_cmp++; if (word_valid !== 1'b1) begin n_bad++; $display("FAIL flush_valid: got %b want 1", word_valid); end
    n_cmp++; if (word_out !== 32'h0000_03FF) begin n_bad++; $display("FAIL flush_word: got %h want 000003ff", word_out); end
    n_cmp++; if (word_len !== 5'd5) begin n_bad++; $display("FAIL flush_len: got %0d want 5", word_len); end
    cyc(0, 0, 1, 1, 1);
    n_cmp++; if (word_valid !== 1'b0) begin n_bad++; $display("FAIL flush_empty1: got %b want 0", word_valid); end
    cyc(0, 0, 0, 1, 1);
    n_cmp++; if (word_valid !== 1'b0) begin n_bad++; $display("FAIL flush_empty2: got %b want 0", word_valid); end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 48; i++) begin
      n_cmp++; if (sym_ready !== m_ready()) begin n_bad++; $display("FAIL bp_ready[%0d]: got %b want %b", i, sym_ready, m_ready()); end
      cyc(1, 2'($urandom), 0, 1, 0);
    end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL bp_ovf: got %b want 1", overflow); end
    n_cmp++; if (sym_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_low: got %b want 0", sym_ready); end
    for (int k = 0; k < 4 && exp_q.size() != 0; k++) begin
      n_cmp++; if (word_valid !== 1'b1) begin n_bad++; $display("FAIL bp_drain_valid[%0d]: got %b want 1", k, word_valid); end
      n_cmp++; if (word_out !== exp_q[0].word) begin n_bad++; $display("FAIL bp_drain_word[%0d]: got %h want %h", k, word_out, exp_q[0].word); end
      n_cmp++; if (word_len !== exp_q[0].len) begin n_bad++; $display("FAIL bp_drain_len[%0d]: got %0d want %0d", k, word_len, exp_q[0].len); end
      cyc(0, 0, 0, 1, 1);
    end
    n_cmp++; if (word_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drained: got %b want 0", word_valid); end
    cyc(0, 0, 1, 1, 0);
    n_cmp++; if (word_len !== exp_q[0].len || word_out !== exp_q[0].word) begin
      n_bad++; $display("FAIL bp_tail: got %h/%0d want %h/%0d", word_out, word_len, exp_q[0].word, exp_q[0].len); end
    cyc(0, 0, 0, 1, 1);
  endtask

  task automatic test_flush_on_16th();
    for (int i = 0; i < 15; i++) cyc(1, 2'($urandom), 0, 1, 1);
    cyc(1, 2'($urandom), 1, 1, 1);
    n_cmp++; if (word_len !== 5'd16) begin n_bad++; $display("FAIL f16_len: got %0d want 16", word_len); end
    n_cmp++; if (word_out !== exp_q[0].word) begin n_bad++; $display("FAIL f16_word: got %h want %h", word_out, exp_q[0].word); end
    cyc(0, 0, 1, 1, 1);
    n_cmp++; if (word_valid !== 1'b0) begin n_bad++; $display("FAIL f16_single_push: got %b want 0", word_valid); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 9; i++) cyc(1, 2'($urandom), 0, 1, 1);
    rst_n = 1'b0; m_clear(); #1;
    n_cmp++; if (sym_ready !== 1'b1 || word_valid !== 1'b0) begin
      n_bad++; $display("FAIL rmid_state: got ready=%b valid=%b want 1/0", sym_ready, word_valid); end
    release_reset();
    for (int i = 0; i < 34; i++) cyc(1, 2'($urandom), 0, 1, 0);
    n_cmp++; if (overflow !== 1'b1 || word_valid !== 1'b1) begin
      n_bad++; $display("FAIL rfull_pre: got ovf=%b valid=%b want 1/1", overflow, word_valid); end
    #2; rst_n = 1'b0; m_clear(); #1;
    n_cmp++; if (word_valid !== 1'b0) begin n_bad++; $display("FAIL rfull_valid: got %b want 0", word_valid); end
    n_cmp++; if (sym_ready !== 1'b1) begin n_bad++; $display("FAIL rfull_ready: got %b want 1", sym_ready); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL rfull_ovf: got %b want 0", overflow); end
    n_cmp++; if (word_out !== 32'h0) begin n_bad++; $display("FAIL rfull_word: got %h want 0", word_out); end
    release_reset();
    for (int i = 0; i < 16; i++) cyc(1, 2'($urandom), 0, 1, 1);
    n_cmp++; if (word_valid !== 1'b1 || word_out !== exp_q[0].word || word_len !== 5'd16) begin
      n_bad++; $display("FAIL rclean: got %b %h/%0d want 1 %h/16", word_valid, word_out, word_len, exp_q[0].word); end
    cyc(0, 0, 0, 1, 1);
  endtask

  task automatic test_en_hold();
    for (int i = 0; i < 19; i++) cyc(1, 2'($urandom), 0, 1, 0);
    for (int i = 0; i < 3; i++) cyc(1, 2'($urandom), 1, 0, 1);
    n_cmp++; if (word_valid !== 1'b0) begin n_bad++; $display("FAIL en_drain: got %b want 0", word_valid); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL en_ovf: got %b want 0", overflow); end
    for (int i = 0; i < 13; i++) cyc(1, 2'($urandom), 0, 1, 0);
    n_cmp++; if (word_valid !== 1'b1 || word_out !== exp_q[0].word || word_len !== 5'd16) begin
      n_bad++; $display("FAIL en_word: got %b %h/%0d want 1 %h/16", word_valid, word_out, word_len, exp_q[0].word); end
    cyc(0, 0, 0, 1, 1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      n_cmp++; if (word_valid !== (exp_q.size() != 0)) begin n_bad++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, word_valid, exp_q.size() != 0); end
      n_cmp++; if (sym_ready !== m_ready()) begin n_bad++; $display("FAIL rnd_ready[%0d]: got %b want %b", i, sym_ready, m_ready()); end
      n_cmp++; if (overflow !== ovf_m) begin n_bad++; $display("FAIL rnd_ovf[%0d]: got %b want %b", i, overflow, ovf_m); end
      if (exp_q.size() != 0) begin
        n_cmp++; if (word_out !== exp_q[0].word || word_len !== exp_q[0].len) begin
          n_bad++; $display("FAIL rnd_head[%0d]: got %h/%0d want %h/%0d", i, word_out, word_len, exp_q[0].word, exp_q[0].len); end
      end
      cyc($urandom_range(0, 3) != 0, 2'($urandom), $urandom_range(0, 11) == 0,
          $urandom_range(0, 7) != 0, $urandom_range(0, 15) < (i < 300 ? 1 : 8));
    end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_flush();
    test_backpressure();
    test_flush_on_16th();
    test_reset_mid();
    test_en_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
